// File: rtl/serial_add_sequencer_if.sv
// Command/result bundle between an add requester and the bit-serial adder sequencer.
// The master issues start with operands; the slave reports busy/done and the registered result.
interface serial_add_sequencer_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, input busy, done, sum, cout);
  modport slave  (input start, a, b, output busy, done, sum, cout);
endinterface

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder controller: drives one full-adder cell over WIDTH bits, LSB first,
// and publishes a registered sum/cout with a one-cycle done pulse.
module serial_add_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  serial_add_sequencer_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  sa_q, sa_d;
  logic [WIDTH-1:0]  sb_q, sb_d;
  logic [WIDTH-1:0]  r_q, r_d;
  logic              c_q, c_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              s_bit;
  logic              c_next;

  // Shared 1-bit adder cell built from two half adders; returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    logic h1_s, h1_c, h2_s, h2_c;
    h1_s = x ^ y;
    h1_c = x & y;
    h2_s = h1_s ^ ci;
    h2_c = h1_s & ci;
    return {h1_c | h2_c, h2_s};
  endfunction

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    r_d     = r_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
    {c_next, s_bit} = full_add(sa_q[0], sb_q[0], c_q);

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          sa_d    = bus.a;
          sb_d    = bus.b;
          r_d     = {WIDTH{1'b0}};
          c_d     = 1'b0;
          cnt_d   = {CW{1'b0}};
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        sa_d = {1'b0, sa_q[WIDTH-1:1]};
        sb_d = {1'b0, sb_q[WIDTH-1:1]};
        r_d  = {s_bit, r_q[WIDTH-1:1]};
        c_d  = c_next;
        // The counter holds on the final bit so it never wraps for power-of-two widths.
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          sum_d   = {s_bit, r_q[WIDTH-1:1]};
          cout_d  = c_next;
        end else begin
          cnt_d   = cnt_q + CW'(1'b1);
          busy_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        sa_d    = {WIDTH{1'b0}};
        sb_d    = {WIDTH{1'b0}};
        r_d     = {WIDTH{1'b0}};
        c_d     = 1'b0;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sa_q    <= {WIDTH{1'b0}};
      sb_q    <= {WIDTH{1'b0}};
      r_q     <= {WIDTH{1'b0}};
      c_q     <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      r_q     <= r_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: doc/serial_add_sequencer.md
# serial_add_sequencer

Bit-serial addition controller that sequences a single 1-bit adder cell (two half adders, xor/and, plus an OR for carry merge) over WIDTH-bit operands, LSB first. It sits between a requester issuing add commands and the shared 1-bit adder datapath. It owns operand capture, carry storage, bit counting and result assembly. It signals completion with a one-cycle pulse.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock; the only clock in the block.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  command request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; sum and cout are valid in this cycle.
- sum  output  WIDTH  registered result (a + b) mod 2^WIDTH.
- cout  output  1  registered carry out of bit WIDTH-1.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - if start=1 at a rising edge: load a into shift register sa and b into sb; clear carry flop c and bit counter cnt; go to RUN.
  - otherwise stay in IDLE.
- RUN, at each edge:
  - bit i is computed by the adder cell: s_i = sa[0]^sb[0]^c, c_next = (sa[0]&sb[0]) | ((sa[0]^sb[0])&c).
  - s_i is shifted into the MSB of result register r, which shifts right.
  - sa and sb shift right; c <= c_next; cnt <= cnt+1.
  - on the edge where cnt = WIDTH-1: go to DONE; load sum <= completed r; load cout <= c_next.
- DONE: done=1 for exactly this cycle; go to IDLE at the next edge unconditionally.
- start is ignored in RUN and DONE; no queuing, no error flag.
- a and b may change freely after the accepting edge; the result depends only on the captured values.
- sum and cout update only on the RUN->DONE edge. They hold their value through IDLE and through the following RUN, until the next operation completes.
- Counter width is clog2(WIDTH); it never wraps within an operation.
- Reset (rst_n=0, any state, including mid-RUN):
  - immediately forces IDLE and clears busy, done, sum, cout, sa, sb, r, c and cnt to 0.
  - the operation in progress is discarded; no done pulse is produced for it.
  - the first start is sampled at the first rising edge after rst_n is released.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0.
- Let E0 be the edge that accepts start. Then:
  - busy=1 from E0 through E(WIDTH).
  - busy=0 and done=1 from E(WIDTH) to E(WIDTH+1).
  - at E(WIDTH+1) the block returns to IDLE.
- Latency from accept to done is WIDTH cycles.
- The earliest next accept is E(WIDTH+2).
- Maximum throughput is one operation per WIDTH+2 cycles.
- If start is held high continuously, operations are accepted back-to-back every WIDTH+2 cycles.
- busy and done are never high together.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, one-cycle start -> busy high for 8 cycles, then done pulses for one cycle with sum=0x96, cout=0.
- a=0xFF, b=0x01 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF -> sum=0xFE, cout=1. Then a=0x00, b=0x00 -> sum=0x00, cout=0.
- Accept a=0x10, b=0x20; pulse start and change a/b to 0xFF in cycles 3 and 5 of RUN -> sum=0x30, cout=0 and exactly one done pulse.
- Drive rst_n=0 asynchronously in the 4th RUN cycle of a=0xAA, b=0x55 -> busy, sum and cout go to 0 immediately with no done pulse; a new op a=0x01, b=0x02 after release -> sum=0x03.
- Hold start=1 for 30 cycles with a=0x80, b=0x80 -> done pulses at cycles 8, 18 and 28 after the first accept, each with sum=0x00, cout=1.
- WIDTH=2 instance, all 16 operand pairs -> sum/cout match a+b; done pulses exactly 2 cycles after each accept.
